// File: rtl/vid_palette_loader_if.sv
// vid_palette_loader_if: byte stream in and palette RAM write port out, grouped for the loader
interface vid_palette_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  pal_w_addr_0;
  logic [15:0] pal_w_data_0;
  logic        pal_w_ena_0;
  modport master (
    output in_data, in_valid,
    input  in_ready, pal_w_addr_0, pal_w_data_0, pal_w_ena_0
  );
  modport slave (
    input  in_data, in_valid,
    output in_ready, pal_w_addr_0, pal_w_data_0, pal_w_ena_0
  );
endinterface

// File: rtl/vid_palette_loader.sv
// vid_palette_loader: RGB888 byte triplets to RGB565 palette writes; VID_PALETTE_LOADER_ROUND_EN selects round-to-nearest
module vid_palette_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_start,
  input  logic [7:0] load_base,
  input  logic [8:0] load_count,
  input  logic       load_abort,
  output logic       busy,
  output logic       done,
  vid_palette_loader_if.slave bus
);
  typedef enum logic {IDLE, LOAD} state_t;
`ifdef VID_PALETTE_LOADER_ROUND_EN
  localparam logic [8:0] RND5 = 9'd4;
  localparam logic [8:0] RND6 = 9'd2;
`else
  localparam logic [8:0] RND5 = 9'd0;
  localparam logic [8:0] RND6 = 9'd0;
`endif
  state_t      state;
  logic [7:0]  addr, r_q, g_q, w_addr;
  logic [8:0]  remaining, r_sum, g_sum, b_sum;
  logic [1:0]  comp;
  logic [15:0] w_data, rgb;
  logic        w_ena;
  logic        unused_lsbs;
  // a carry into bit 8 means the rounded value overflowed its field, so saturate
  always_comb begin
    r_sum = {1'b0, r_q} + RND5;
    g_sum = {1'b0, g_q} + RND6;
    b_sum = {1'b0, bus.in_data} + RND5;
    rgb = {r_sum[8] ? 5'd31 : r_sum[7:3], g_sum[8] ? 6'd63 : g_sum[7:2], b_sum[8] ? 5'd31 : b_sum[7:3]};
    unused_lsbs = ^{r_sum[2:0], g_sum[1:0], b_sum[2:0]};
  end
  assign busy = (state == LOAD);
  assign bus.in_ready = busy;
  assign bus.pal_w_addr_0 = w_addr;
  assign bus.pal_w_data_0 = w_data;
  assign bus.pal_w_ena_0 = w_ena;
  // load sequencer: collects R, G, B and emits one registered write per triplet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      remaining <= '0;
      comp <= '0;
      r_q <= '0;
      g_q <= '0;
      w_addr <= '0;
      w_data <= '0;
      w_ena <= 1'b0;
      done <= 1'b0;
    end else begin
      w_ena <= 1'b0;
      done <= 1'b0;
      if (load_abort) begin
        state <= IDLE;
        comp <= '0;
      end else if (state == IDLE) begin
        if (load_start) begin
          state <= LOAD;
          addr <= load_base;
          remaining <= (load_count == '0) ? 9'd256 : load_count;
          comp <= '0;
        end
      end else if (bus.in_valid) begin
        if (comp == 2'd0) begin
          r_q <= bus.in_data;
          comp <= 2'd1;
        end else if (comp == 2'd1) begin
          g_q <= bus.in_data;
          comp <= 2'd2;
        end else begin
          comp <= '0;
          w_addr <= addr;
          w_data <= rgb;
          w_ena <= 1'b1;
          addr <= addr + 8'd1;
          remaining <= remaining - 9'd1;
          if (remaining == 9'd1) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: doc/vid_palette_loader.md
# vid_palette_loader

Stream-to-palette writer for the video pipeline. Accepts a byte stream of 8-bit R, G, B triplets (PLAYPAL-style, 3 bytes per entry), converts each triplet to RGB565 and drives the palette memory's write port (`w_addr_0` / `w_data_0` / `w_ena_0`) one entry per write. It sits between the CPU/DMA byte source and the palette RAM, whose read side feeds the pixel path.

## Interface

Parameters:
- none

Ports:
- `clk` in 1: single clock; also clocks the palette RAM.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load_start` in 1: start pulse; sampled only in IDLE.
- `load_base` in 8: first palette index, latched on start.
- `load_count` in 9: number of entries, latched on start; 0 means 256.
- `load_abort` in 1: return to IDLE; takes priority over everything except reset.
- `in_data` in 8: stream byte.
- `in_valid` in 1: stream byte valid.
- `in_ready` out 1: loader accepts a byte; equals busy.
- `busy` out 1: high while LOAD.
- `done` out 1: one-cycle pulse, concurrent with the final write.
- `pal_w_addr_0` out 8: palette write address.
- `pal_w_data_0` out 16: RGB565 `{R5,G6,B5}`.
- `pal_w_ena_0` out 1: write strobe, one cycle per entry.

## Operation

- States: IDLE, LOAD.
- IDLE → LOAD on `load_start`. Latch `load_base` into the address counter and `load_count` (0 → 256) into the remaining counter. Clear the component counter.
- In LOAD, a byte is accepted on an edge where `in_valid & in_ready`. Component counter: 0 = R, 1 = G, 2 = B. R and G are held in registers.
- On acceptance of B:
  - Component counter → 0.
  - Register the converted word and the current address onto `pal_w_*`.
  - Increment the address, wrapping mod 256 (255 → 0).
  - Decrement remaining. If remaining was 1, go to IDLE and pulse `done` with that write.
- `load_start` while in LOAD is ignored.
- `load_abort`:
  - Goes to IDLE and discards a partial triplet.
  - No write and no `done` on the abort edge.
  - A write already registered on the previous edge still completes.
- Truncating conversion: R5 = R[7:3], G6 = G[7:2], B5 = B[7:3].
- Partial last triplet stays pending until more bytes arrive or abort.
- Reset values: `in_ready` = 0, `busy` = 0, `done` = 0, `pal_w_ena_0` = 0, `pal_w_addr_0` = 0, `pal_w_data_0` = 0. State is IDLE and all counters are 0.
- Reset asserted mid-load: immediate IDLE, no further writes.

## Timing

- `in_ready` / `busy` rise the cycle after the `load_start` edge.
- Write latency: the B byte is accepted at edge N; `pal_w_ena_0`, `pal_w_addr_0` and `pal_w_data_0` are valid during cycle N..N+1. The RAM captures the entry at edge N+1.
- Maximum throughput is 1 byte per cycle, so 1 entry per 3 cycles. `pal_w_ena_0` is never high on two consecutive cycles.
- After the final B accepted at edge N:
  - `in_ready` is 0 from edge N.
  - `done` and the final `pal_w_ena_0` are high together for cycle N..N+1.
  - A new `load_start` is accepted from edge N+1.
- `in_valid` may drop at any time; bubbles only stall.

## Configuration

- `VID_PALETTE_LOADER_ROUND_EN`, when defined, enables round-to-nearest conversion with saturation:
  - R5 = min(31, (R+4)>>3).
  - G6 = min(63, (G+2)>>2).
  - B5 = min(31, (B+4)>>3).
  - Intermediate sums are 9 bits wide.
- When undefined, conversion is truncating as described in Operation.
- Timing is identical in both builds.

## Test plan

- Start with base=0x10, count=1; send bytes 0xFF, 0x80, 0x00 at full rate -> exactly one write, addr 0x10, data 0xFC00 in both builds. `done` is coincident with the write, `busy` is low after it.
- Single entry with R,G,B = 0x0C, 0x03, 0x1C -> data 0x0803 without `VID_PALETTE_LOADER_ROUND_EN`, 0x1024 with it.
- Start with base=0xFE, count=4; send 12 bytes with random `in_valid` gaps -> writes to addresses 0xFE, 0xFF, 0x00, 0x01 in order. Every strobe is single-cycle, and `done` accompanies only the 4th write.
- Start with count=0; send 768 bytes -> 256 writes covering every address once, starting and ending at base-wrapped addresses.
- Abort after 5 bytes of a count=3 load -> one write only, no `done`, IDLE next cycle. A following load starts cleanly at its new base with R as the first byte.
- Assert `rst_n` low mid-triplet, and assert `load_start` during LOAD -> all outputs return to reset values asynchronously; the spurious start has no effect on address or count.
